dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder. It is the far end of the load/store request interface driven by the mem stage.
//  - Accepts one read or write request at a time.
//  - Applies WAIT_STATES cycles of access delay.
//  - Performs the access on a private byte-writable SRAM.
//  - Returns a single-cycle hit pulse with 16-bit read data (or an error flag) to the mem stage.
// PARAMETERS
//  XLEN         32            request address/data width (matches cpu_parameters::xlen)
//  DEPTH_WORDS  1024          SRAM depth in 32-bit words (power of 2)
//  BASE_ADR     32'h0001_0000 byte address of SRAM word 0 (DEPTH_WORDS*4 aligned)
//  WAIT_STATES  1             extra cycles between acceptance and SRAM access (0..15)
// PORTS
//  clk            in   1     clock, all logic on rising edge
//  rst            in   1     synchronous reset, active-high
//  r_v            in   1     read request valid
//  w_v            in   1     write request valid
//  req_adr        in   XLEN  byte address
//  req_data       in   XLEN  write data, unshifted (value in low bits)
//  req_strobe     in   4     byte-lane enables, lane k = address bits [1:0]==k
//  hit            out  1     one-cycle response pulse
//  mem_res        out  16    read data, valid while hit=1
//  mem_res_error  out  1     access faulted, valid while hit=1
//  busy           out  1     a request is in flight; new requests are ignored
// BEHAVIOUR
//  Reset: all outputs are 0 (hit, mem_res, mem_res_error, busy). FSM goes to IDLE and the wait counter is cleared.
//  FSM states:
//  - IDLE: on (r_v|w_v), capture adr/data/strobe/kind into registers (accept).
//    - Go to WAIT if WAIT_STATES>0, else go to ACC.
//  - WAIT: count down WAIT_STATES cycles, then go to ACC.
//  - ACC: one cycle. SRAM enable is asserted; for a write, byte-enables are asserted (gated by !rst).
//  - RESP: hit=1 for exactly one cycle, then go to IDLE.
//  Latency: hit is asserted exactly WAIT_STATES+2 cycles after the acceptance cycle, for reads, writes and errors alike.
//  busy is 1 in WAIT, ACC and RESP.
//  Handshake:
//  - The requester holds r_v/w_v and the request fields stable until hit.
//  - A request visible during the hit cycle is not accepted.
//  - Acceptance happens no earlier than the cycle after hit; back-to-back throughput is 1 request per WAIT_STATES+3 cycles.
//  Error check (done at acceptance, any one of these sets the error):
//  - r_v & w_v both asserted.
//  - off = req_adr - BASE_ADR gives off >= DEPTH_WORDS*4 (unsigned compare, so addresses below BASE_ADR also fault).
//  - strobe is not one of: 0001/0010/0100/1000, 0011 with adr[1:0]=0, 0110 with adr[1:0]=1, 1100 with adr[1:0]=2, 1111 with adr[1:0]=0.
//  - Strobe lane not equal to adr[1:0] for single-byte strobes.
//  On error: SRAM is untouched; response has mem_res_error=1, mem_res=16'h0.
//  Write lane steering: SRAM wdata = req_data << (8*adr[1:0]); byte-enables = strobe.
//  - write hit returns mem_res=0 and mem_res_error=0.
//  Read lane steering from the 32-bit word W:
//  - single-byte strobe at lane k: mem_res = {8'h00, W[8k+7:8k]}.
//  - 0011 -> W[15:0]; 0110 -> W[23:8]; 1100 -> W[31:16].
//  - 1111 -> W[15:0] (16-bit return bus; full-word reads return the low half).
//  mem_res/mem_res_error are registered and held at 0 outside RESP.
//  Reset mid-operation:
//  - rst in WAIT/ACC aborts the request with no SRAM write and no hit.
//  - rst during RESP drops hit in the next cycle.
//  Simultaneous rst and request: rst wins, nothing accepted.
//  SRAM word index = off[log2(DEPTH_WORDS)+1:2]; no wrap-around, out-of-range always faults.
// STRUCTURE
//  cpu_parameters package gains:
//  - typedef enum logic[1:0] {DM_IDLE, DM_WAIT, DM_ACC, DM_RESP} dmem_state_t
//  - DMEM_BASE_ADR and DMEM_DEPTH_WORDS default constants.
//  One sub-module: dmem_sram. It is a synchronous 1-port SRAM: en, we[3:0], adr, wdata[31:0], rdata[31:0]; read data is valid the cycle after en.
//  The FSM, error check and lane steering stay in dmem_responder.
// TESTING (WAIT_STATES=1, BASE_ADR=32'h0001_0000 unless noted)
//  1. Word round-trip:
//     - Write adr 0x10010, strb 1111, data 0xDEADBEEF -> hit 3 cycles after accept, error 0.
//     - Read 0x10010 strb 0011 -> mem_res 0xBEEF.
//     - Read 0x10012 strb 1100 -> mem_res 0xDEAD.
//  2. Byte lanes:
//     - Write adr 0x10005, strb 0010, data 0x000000A5.
//     - Read 0x10005 strb 0010 -> 0x00A5.
//     - Read 0x10004 strb 0011 -> low byte unchanged, high byte 0xA5.
//  3. Faults, each -> hit at +3 with error=1 and mem_res=0, SRAM contents unchanged:
//     - Read 0x10000+4*DEPTH_WORDS.
//     - Read 0x0000FFFC.
//     - r_v=w_v=1.
//     - strb 1111 at 0x10012.
//  4. Reset mid-op: write 0x10020 data 0x12345678, rst pulsed 1 cycle while in WAIT -> no hit, busy=0 next cycle; read 0x10020 returns old data.
//  5. Back-to-back: second request presented in the hit cycle of the first -> ignored until the following cycle; second hit exactly 4 cycles after the first.
//  6. WAIT_STATES=0 build: read request -> hit exactly 2 cycles after the accept cycle.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared FSM type, default geometry and lane helpers for the data-memory responder
package dmem_responder_pkg;
  typedef enum logic [1:0] {DM_IDLE, DM_WAIT, DM_ACC, DM_RESP} dmem_state_t;
  localparam logic [31:0] DMEM_BASE_ADR = 32'h0001_0000;
  localparam int DMEM_DEPTH_WORDS = 1024;
  function automatic logic strobe_ok(input logic [3:0] s, input logic [1:0] a);
    return (s == (4'b0001 << a)) || (s == 4'b0011 && a == 2'd0) || (s == 4'b0110 && a == 2'd1) ||
           (s == 4'b1100 && a == 2'd2) || (s == 4'b1111 && a == 2'd0);
  endfunction
  function automatic logic [15:0] read_lane(input logic [31:0] w, input logic [3:0] s, input logic [1:0] a);
    return $onehot(s) ? {8'h00, 8'(w >> {a, 3'b000})} : 16'(w >> {a, 3'b000});
  endfunction
endpackage

// File: rtl/dmem_responder_sram.sv
// dmem_responder_sram: synchronous single-port byte-writable SRAM, read data valid the cycle after en
module dmem_responder_sram #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] adr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [3:0][7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      for (int b = 0; b < 4; b++)
        if (we[b]) mem[adr][b] <= wdata[8*b +: 8];
      rdata <= mem[adr];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store responder with wait states, fault checking and 16-bit lane-steered read return
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADR    = DMEM_BASE_ADR,
  parameter int          WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r_v,
  input  logic            w_v,
  input  logic [XLEN-1:0] req_adr,
  input  logic [XLEN-1:0] req_data,
  input  logic [3:0]      req_strobe,
  output logic            hit,
  output logic [15:0]     mem_res,
  output logic            mem_res_error,
  output logic            busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  dmem_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, strb_q, strb_d;
  logic [1:0] lane_q, lane_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0] data_q, data_d, rdata;
  logic wr_q, wr_d, err_q, err_d;
  logic [XLEN-1:0] off;
  logic accept, sram_en;
  logic [3:0] sram_we;
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= DM_IDLE;
      cnt_q   <= '0;
      strb_q  <= '0;
      lane_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      strb_q  <= strb_d;
      lane_q  <= lane_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  always_comb begin
    off     = req_adr - XLEN'(BASE_ADR);
    accept  = state_q == DM_IDLE && (r_v || w_v);
    state_d = state_q == DM_IDLE ? (accept ? (WAIT_STATES > 0 ? DM_WAIT : DM_ACC) : DM_IDLE) :
              state_q == DM_WAIT ? (cnt_q == 4'd0 ? DM_ACC : DM_WAIT) :
              state_q == DM_ACC  ? DM_RESP : DM_IDLE;
    cnt_d   = accept ? 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0) :
              (state_q == DM_WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    strb_d  = accept ? req_strobe : strb_q;
    lane_d  = accept ? req_adr[1:0] : lane_q;
    idx_d   = accept ? off[AW+1:2] : idx_q;
    data_d  = accept ? req_data[31:0] : data_q;
    wr_d    = accept ? w_v : wr_q;
    err_d   = accept ? ((r_v && w_v) || off >= XLEN'(DEPTH_WORDS * 4) || !strobe_ok(req_strobe, req_adr[1:0])) : err_q;
  end
  always_comb begin
    sram_en       = state_q == DM_ACC && !err_q && !rst;
    sram_we       = (sram_en && wr_q) ? strb_q : 4'b0000;
    hit           = state_q == DM_RESP;
    busy          = state_q != DM_IDLE;
    mem_res_error = hit && err_q;
    mem_res       = (hit && !err_q && !wr_q) ? read_lane(rdata, strb_q, lane_q) : 16'h0000;
  end
  dmem_responder_sram #(.DEPTH(DEPTH_WORDS)) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (sram_we),
    .adr   (idx_q),
    .wdata (data_q << {lane_q, 3'b000}),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (WAIT_STATES=1 main instance, WAIT_STATES=0 latency instance)
module tb_dmem_responder;
  typedef struct {
    string       name;
    logic [15:0] res;
    logic        err;
    int          due;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic r_v = 1'b0, w_v = 1'b0;
  logic [31:0] req_adr = '0, req_data = '0;
  logic [3:0] req_strobe = '0;
  logic hit, mem_res_error, busy;
  logic [15:0] mem_res;
  logic r0_v = 1'b0, w0_v = 1'b0;
  logic [31:0] adr0 = '0, data0 = '0;
  logic [3:0] strb0 = '0;
  logic hit0, err0, busy0;
  logic [15:0] res0;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  exp_t sbq[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dmem_responder #(.WAIT_STATES(1)) dut (
    .clk(clk), .rst(rst), .r_v(r_v), .w_v(w_v), .req_adr(req_adr), .req_data(req_data),
    .req_strobe(req_strobe), .hit(hit), .mem_res(mem_res), .mem_res_error(mem_res_error), .busy(busy)
  );
  dmem_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .r_v(r0_v), .w_v(w0_v), .req_adr(adr0), .req_data(data0),
    .req_strobe(strb0), .hit(hit0), .mem_res(res0), .mem_res_error(err0), .busy(busy0)
  );
  always @(negedge clk)
    if (hit) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_hit: got hit at cyc=%0d res=%h err=%b, want no hit", cyc, mem_res, mem_res_error);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (mem_res !== e.res || mem_res_error !== e.err || cyc != e.due) begin
          n_bad++;
          $display("FAIL %s: got res=%h err=%b cyc=%0d, want res=%h err=%b cyc=%0d",
                   e.name, mem_res, mem_res_error, cyc, e.res, e.err, e.due);
        end
      end
    end
  task automatic wait_hit(input string nm);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hit) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s_timeout: got no hit in 20 cycles, want hit", nm);
  endtask
  task automatic push(input string nm, input logic [15:0] er, input logic ee, input int due);
    exp_t e;
    e.name = nm;
    e.res  = er;
    e.err  = ee;
    e.due  = due;
    sbq.push_back(e);
  endtask
  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    r_v = r;
    w_v = w;
    req_adr = a;
    req_data = d;
    req_strobe = s;
  endtask
  task automatic do_req(input string nm, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input logic [15:0] er, input logic ee);
    @(posedge clk);
    #1;
    drive(r, w, a, d, s);
    push(nm, er, ee, cyc + 3);
    wait_hit(nm);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, '0, '0, '0);
  endtask
  task automatic do_req0(input string nm, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic [15:0] er);
    int c0;
    bit seen;
    @(posedge clk);
    #1;
    r0_v = r;
    w0_v = w;
    adr0 = a;
    data0 = d;
    strb0 = s;
    c0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = hit0;
    end
    n_cmp++;
    if (!seen || cyc - c0 != 2 || res0 !== er || err0 !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got seen=%b lat=%0d res=%h err=%b, want seen=1 lat=2 res=%h err=0",
               nm, seen, cyc - c0, res0, err0, er);
    end
    @(posedge clk);
    #1;
    r0_v = 1'b0;
    w0_v = 1'b0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({hit, mem_res, mem_res_error, busy, hit0, res0, err0, busy0} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got hit=%b res=%h err=%b busy=%b hit0=%b res0=%h err0=%b busy0=%b, want all 0",
               hit, mem_res, mem_res_error, busy, hit0, res0, err0, busy0);
    end
    do_req("w_word",        1'b0, 1'b1, 32'h0001_0010, 32'hDEADBEEF, 4'b1111, 16'h0000, 1'b0);
    do_req("r_lo_half",     1'b1, 1'b0, 32'h0001_0010, 32'h0,        4'b0011, 16'hBEEF, 1'b0);
    do_req("r_hi_half",     1'b1, 1'b0, 32'h0001_0012, 32'h0,        4'b1100, 16'hDEAD, 1'b0);
    do_req("r_byte0",       1'b1, 1'b0, 32'h0001_0010, 32'h0,        4'b0001, 16'h00EF, 1'b0);
    do_req("r_byte3",       1'b1, 1'b0, 32'h0001_0013, 32'h0,        4'b1000, 16'h00DE, 1'b0);
    do_req("r_mid_half",    1'b1, 1'b0, 32'h0001_0011, 32'h0,        4'b0110, 16'hADBE, 1'b0);
    do_req("r_full_word",   1'b1, 1'b0, 32'h0001_0010, 32'h0,        4'b1111, 16'hBEEF, 1'b0);
    do_req("w_word4",       1'b0, 1'b1, 32'h0001_0004, 32'h11223344, 4'b1111, 16'h0000, 1'b0);
    do_req("w_byte1",       1'b0, 1'b1, 32'h0001_0005, 32'h000000A5, 4'b0010, 16'h0000, 1'b0);
    do_req("r_byte1",       1'b1, 1'b0, 32'h0001_0005, 32'h0,        4'b0010, 16'h00A5, 1'b0);
    do_req("r_lo_after_b",  1'b1, 1'b0, 32'h0001_0004, 32'h0,        4'b0011, 16'hA544, 1'b0);
    do_req("r_hi_after_b",  1'b1, 1'b0, 32'h0001_0006, 32'h0,        4'b1100, 16'h1122, 1'b0);
    do_req("w_word0",       1'b0, 1'b1, 32'h0001_0000, 32'h55667788, 4'b1111, 16'h0000, 1'b0);
    do_req("f_r_above",     1'b1, 1'b0, 32'h0001_1000, 32'h0,        4'b1111, 16'h0000, 1'b1);
    do_req("f_w_above",     1'b0, 1'b1, 32'h0001_1000, 32'h0,        4'b1111, 16'h0000, 1'b1);
    do_req("f_r_below",     1'b1, 1'b0, 32'h0000_FFFC, 32'h0,        4'b1111, 16'h0000, 1'b1);
    do_req("f_rw_both",     1'b1, 1'b1, 32'h0001_0010, 32'h0,        4'b1111, 16'h0000, 1'b1);
    do_req("f_word_unal",   1'b0, 1'b1, 32'h0001_0012, 32'h0,        4'b1111, 16'h0000, 1'b1);
    do_req("f_lane_mis",    1'b0, 1'b1, 32'h0001_0011, 32'h0,        4'b0001, 16'h0000, 1'b1);
    do_req("f_strb_zero",   1'b0, 1'b1, 32'h0001_0010, 32'h0,        4'b0000, 16'h0000, 1'b1);
    do_req("r_after_f0",    1'b1, 1'b0, 32'h0001_0000, 32'h0,        4'b0011, 16'h7788, 1'b0);
    do_req("r_after_f_lo",  1'b1, 1'b0, 32'h0001_0010, 32'h0,        4'b1111, 16'hBEEF, 1'b0);
    do_req("r_after_f_hi",  1'b1, 1'b0, 32'h0001_0012, 32'h0,        4'b1100, 16'hDEAD, 1'b0);
    do_req("w_word20",      1'b0, 1'b1, 32'h0001_0020, 32'hCAFEF00D, 4'b1111, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 32'h0001_0020, 32'h12345678, 4'b1111);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_after_rst: got busy=%b, want 0", busy);
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_idle_after_rst: got busy=%b, want 0", busy);
    end
    do_req("r_rst_lo",      1'b1, 1'b0, 32'h0001_0020, 32'h0,        4'b0011, 16'hF00D, 1'b0);
    do_req("r_rst_hi",      1'b1, 1'b0, 32'h0001_0022, 32'h0,        4'b1100, 16'hCAFE, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 32'h0001_0010, 32'h0, 4'b0011);
    push("b2b_first", 16'hBEEF, 1'b0, cyc + 3);
    wait_hit("b2b_first");
    drive(1'b1, 1'b0, 32'h0001_0012, 32'h0, 4'b1100);
    push("b2b_second", 16'hDEAD, 1'b0, cyc + 4);
    wait_hit("b2b_second");
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, '0, '0, '0);
    do_req0("ws0_write", 1'b0, 1'b1, 32'h0001_0000, 32'h0000BEAD, 4'b1111, 16'h0000);
    do_req0("ws0_read",  1'b1, 1'b0, 32'h0001_0000, 32'h0,        4'b0011, 16'hBEAD);
    repeat (4) @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_hits: got %0d expected responses left, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
